// File: rtl/as2650_bus_bridge.sv
// Bridge from the 2650 multiplexed CPU bus to a simple req/ack memory port.
// Latches the address, turns strobe falling edges into single memory accesses, and times out stalled accesses.
module as2650_bus_bridge #(
    parameter int AW      = 13,
    parameter int TIMEOUT = 15
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [7:0]    cpu_bus_o,
    output logic [7:0]    cpu_bus_i,
    input  logic          le_lo,
    input  logic          le_hi,
    input  logic          OEb,
    input  logic          WEb,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          rd_valid,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_REQ,
        WAIT_REL
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_nx;
    logic [7:0]     addr_lo;
    logic [7:0]     addr_hi;
    logic [15:0]    addr_full;
    logic           oeb_q;
    logic           oeb_qq;
    logic           web_q;
    logic           web_qq;
    logic           oe_fall;
    logic           we_fall;
    logic [CW-1:0]  cnt;
    logic           timed_out;
    logic           in_req;

    assign addr_full = {addr_hi, addr_lo};
    assign oe_fall   = oeb_qq & ~oeb_q;
    assign we_fall   = web_qq & ~web_q;
    assign in_req    = (state == RD_REQ) || (state == WR_REQ);
    // An ack in the final allowed cycle still wins over the timeout.
    assign timed_out = (cnt == CW'(TIMEOUT - 1)) && !mem_ack;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_lo <= '0;
            addr_hi <= '0;
        end else begin
            if (le_lo) addr_lo <= cpu_bus_o;
            if (le_hi) addr_hi <= cpu_bus_o;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            oeb_q  <= 1'b1;
            oeb_qq <= 1'b1;
            web_q  <= 1'b1;
            web_qq <= 1'b1;
        end else begin
            oeb_q  <= OEb;
            oeb_qq <= oeb_q;
            web_q  <= WEb;
            web_qq <= web_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (we_fall)      state_nx = WR_REQ;
                else if (oe_fall) state_nx = RD_REQ;
            end
            RD_REQ: begin
                if (mem_ack)        state_nx = RD_HOLD;
                else if (timed_out) state_nx = WAIT_REL;
            end
            RD_HOLD: begin
                if (oeb_q) state_nx = IDLE;
            end
            WR_REQ: begin
                if (mem_ack || timed_out) state_nx = WAIT_REL;
            end
            WAIT_REL: begin
                if (web_q) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req = in_req;
        mem_we  = (state == WR_REQ);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_bus_i <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (we_fall) begin
                        mem_addr  <= addr_full[AW-1:0];
                        mem_wdata <= cpu_bus_o;
                    end else if (oe_fall) begin
                        mem_addr <= addr_full[AW-1:0];
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (mem_ack) begin
                        cnt <= '0;
                        if (state == RD_REQ) begin
                            cpu_bus_i <= mem_rdata;
                            rd_valid  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        cnt <= '0;
                        err <= 1'b1;
                        if (state == RD_REQ) begin
                            cpu_bus_i <= 8'hFF;
                            rd_valid  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (oeb_q) rd_valid <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/as2650_bus_bridge.md
AS2650_BUS_BRIDGE -- requirements
Module: as2650_bus_bridge

Interface
REQ-001 Parameter AW, default 13: width of mem_addr; latched CPU address is truncated to bits [AW-1:0], so the 8 KiB space wraps modulo 2^AW.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ack before the access is abandoned.
REQ-003 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 cpu_bus_o  input  8  CPU multiplexed address/data output.
REQ-006 cpu_bus_i  output  8  read data returned to the CPU.
REQ-007 le_lo  input  1  CPU low address latch enable.
REQ-008 le_hi  input  1  CPU high address latch enable.
REQ-009 OEb  input  1  CPU read strobe, active-low.
REQ-010 WEb  input  1  CPU write strobe, active-low.
REQ-011 mem_req  output  1  memory request; held high until mem_ack.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-013 mem_addr  output  AW  memory address; valid while mem_req is high.
REQ-014 mem_wdata  output  8  write data; valid while mem_req is high.
REQ-015 mem_rdata  input  8  read data; sampled in the cycle mem_ack is high.
REQ-016 mem_ack  input  1  single-cycle completion from memory.
REQ-017 rd_valid  output  1  cpu_bus_i holds data for the current read.
REQ-018 err  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-019 addr_lo SHALL load cpu_bus_o on every cycle le_lo is high, and hold its value while le_lo is low.
REQ-020 addr_hi SHALL load cpu_bus_o on every cycle le_hi is high, and hold its value while le_hi is low.
REQ-021 OEb and WEb SHALL be registered once; a strobe falling edge is registered value 1 in the previous cycle and 0 in the current cycle.
REQ-022 The state machine SHALL have states IDLE, RD_REQ, RD_HOLD, WR_REQ and WAIT_REL.
REQ-023 IDLE, OEb falling edge: go to RD_REQ.
  - mem_req=1, mem_we=0.
  - mem_addr={addr_hi,addr_lo}[AW-1:0].
REQ-024 IDLE, WEb falling edge: go to WR_REQ.
  - mem_req=1, mem_we=1, mem_addr as in REQ-023.
  - mem_wdata=cpu_bus_o, sampled in the edge-detect cycle.
REQ-025 OEb and WEb falling in the same cycle: the write SHALL win and the read SHALL be dropped.
REQ-026 RD_REQ, mem_ack=1: capture mem_rdata into cpu_bus_i, set rd_valid=1, deassert mem_req, go to RD_HOLD.
REQ-027 RD_HOLD: cpu_bus_i and rd_valid SHALL hold until registered OEb=1, then go to IDLE with rd_valid=0 and cpu_bus_i held.
REQ-028 WR_REQ, mem_ack=1: deassert mem_req and go to WAIT_REL.
REQ-029 WAIT_REL: return to IDLE once registered WEb=1.
REQ-030 Timeout counter, RD_REQ or WR_REQ:
  - counts cycles without ack and resets on state entry.
  - on reaching TIMEOUT: set err=1, deassert mem_req, go to WAIT_REL.
  - a timed-out read returns cpu_bus_i=8'hFF with rd_valid=0.
REQ-031 mem_ack outside RD_REQ or WR_REQ SHALL be ignored.
REQ-032 mem_req SHALL be asserted for at least 1 cycle per access; the earliest accepted ack is the cycle after mem_req rises.
REQ-033 A strobe edge arriving while not in IDLE SHALL be ignored; no request is queued.
REQ-034 Latency:
  - strobe fall to mem_req: 2 cycles (1 synchroniser + 1 edge detect).
  - ack to cpu_bus_i and rd_valid valid: 1 cycle.

Reset
REQ-035 While wb_rst_i=1, outputs SHALL take these values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_bus_i=8'h00, rd_valid=0, err=0.
  - state=IDLE, addr_lo=addr_hi=0, timeout counter=0.
  - registered OEb and WEb preset to 1.
REQ-036 Reset asserted mid-access SHALL abort the access immediately.
  - mem_req drops asynchronously.
  - no ack is honoured after reset is released.

Verification
REQ-037 Read: le_hi with 8'h1F, le_lo with 8'h34, OEb low, ack 3 cycles later with 8'hA5.
  - expect mem_addr=13'h1F34, mem_we=0.
  - expect cpu_bus_i=8'hA5, rd_valid=1 until OEb rises.
REQ-038 Write: address 16'h0000, cpu_bus_o=8'h81 when WEb falls.
  - expect mem_req with mem_we=1, mem_addr=0, mem_wdata=8'h81.
  - mem_req drops on ack; FSM returns to IDLE after WEb rises.
REQ-039 Wrap: latched address 16'hE001 -> mem_addr=13'h0001.
REQ-040 Timeout: read with no ack -> after 15 cycles mem_req=0, err=1, cpu_bus_i=8'hFF.
REQ-041 Simultaneous strobes: OEb and WEb fall in the same cycle -> write only, no read request.
REQ-042 Reset mid-access: assert wb_rst_i during RD_REQ, then supply ack after release -> all outputs at reset values, ack ignored, next OEb fall serviced normally.
